// File: rtl/rs_syndrome_calc_if.sv
// Handshake bundle between the RS(7,5) symbol source, the syndrome stage and
// the downstream key-equation stage. The syndrome stage takes the slave view.
interface rs_syndrome_calc_if #(
  parameter int SYMBOL_WIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SYMBOL_WIDTH-1:0] in_symbol;
  logic                    out_valid;
  logic                    out_ready;
  logic [SYMBOL_WIDTH-1:0] syndrome1;
  logic [SYMBOL_WIDTH-1:0] syndrome2;
  logic                    error_detected;

  modport slave (
    input  in_valid, in_symbol, out_ready,
    output in_ready, out_valid, syndrome1, syndrome2, error_detected
  );

  modport master (
    output in_valid, in_symbol, out_ready,
    input  in_ready, out_valid, syndrome1, syndrome2, error_detected
  );
endinterface

// File: rtl/rs_syndrome_calc.sv
// Streaming syndrome stage for RS(7,5) over GF(2^3).
// Symbols arrive highest degree first; S1 = r(a) and S2 = r(a^2) are built by
// Horner's rule and then held with a valid/ready handshake until consumed.
module rs_syndrome_calc #(
  parameter int                      SYMBOL_WIDTH = 3,
  parameter int                      N            = 7,
  parameter logic [SYMBOL_WIDTH:0]   PRIM_POLY    = 4'b1011
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rs_syndrome_calc_if.slave    bus
);

  localparam int                CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  typedef logic [SYMBOL_WIDTH-1:0] sym_t;

  // Multiply by alpha in polynomial basis: shift up, fold the overflow bit
  // back through the primitive polynomial. For x^3+x+1 this is
  // {s[1], s[0]^s[2], s[2]}.
  function automatic sym_t mul_alpha(input sym_t s);
    sym_t r;
    r = {s[SYMBOL_WIDTH-2:0], 1'b0};
    if (s[SYMBOL_WIDTH-1]) begin
      r = r ^ PRIM_POLY[SYMBOL_WIDTH-1:0];
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  sym_t              acc1_q, acc2_q;
  sym_t              acc1_nxt, acc2_nxt;
  sym_t              syn1_q, syn2_q;
  logic              err_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept;
  logic              last_accept;
  logic              release_word;

  // Horner step for both evaluation points; used only when a symbol is accepted.
  always_comb begin
    acc1_nxt = mul_alpha(acc1_q) ^ bus.in_symbol;
    acc2_nxt = mul_alpha(mul_alpha(acc2_q)) ^ bus.in_symbol;
  end

  // Next-state and control decode for the COLLECT/HOLD controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    accept       = 1'b0;
    last_accept  = 1'b0;
    release_word = 1'b0;
    case (state_q)
      COLLECT: begin
        // in_ready_q rather than the state gates acceptance, so the cycle
        // right after reset release cannot take a symbol.
        accept = bus.in_valid & in_ready_q;
        if (accept && (count_q == CNT_LAST)) begin
          last_accept = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          release_word = 1'b1;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered handshake flags, derived from the state being entered so both
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == COLLECT);
      out_valid_q <= (state_d == HOLD);
    end
  end

  // Accumulators and symbol counter; cleared when the held result is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      count_q <= '0;
    end else if (release_word) begin
      acc1_q  <= '0;
      acc2_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      acc1_q  <= acc1_nxt;
      acc2_q  <= acc2_nxt;
      count_q <= last_accept ? '0 : count_q + 1'b1;
    end
  end

  // Result registers: loaded with the final Horner step, held until the next word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syn1_q <= '0;
      syn2_q <= '0;
      err_q  <= 1'b0;
    end else if (last_accept) begin
      syn1_q <= acc1_nxt;
      syn2_q <= acc2_nxt;
      err_q  <= (|acc1_nxt) | (|acc2_nxt);
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.syndrome1      = syn1_q;
  assign bus.syndrome2      = syn2_q;
  assign bus.error_detected = err_q;

endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Streaming syndrome stage for the RS(7,5) decoder over GF(2^3).
- Accepts one received codeword symbol per handshake, highest-degree coefficient first.
- Accumulates S1 = r(α) and S2 = r(α^2) by Horner's rule.
- Presents both syndromes plus an error flag to the downstream key-equation/error-locator stage through a valid/ready handshake.

Parameters:
- SYMBOL_WIDTH, 3, bits per GF symbol (matches `SYMBOL_WIDTH).
- N, 7, codeword length in symbols (matches `N).
- PRIM_POLY, 4'b1011, field primitive polynomial x^3+x+1, polynomial basis; α = 3'b010.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_symbol is valid this cycle.
- in_ready  output  1  block can accept a symbol this cycle.
- in_symbol  input  SYMBOL_WIDTH  received symbol r_i, polynomial basis; first symbol is degree N-1.
- out_valid  output  1  syndromes are valid and held.
- out_ready  input  1  downstream consumes the syndromes this cycle.
- syndrome1  output  SYMBOL_WIDTH  S1 = r(α).
- syndrome2  output  SYMBOL_WIDTH  S2 = r(α^2).
- error_detected  output  1  (syndrome1 != 0) | (syndrome2 != 0); qualified by out_valid.

Behaviour:
- Reset (async assert, sync deassert use):
  - state = COLLECT, symbol count = 0, both accumulators = 0.
  - out_valid = 0, syndrome1/2 = 0, error_detected = 0.
  - in_ready = 1 from the first clock after reset deasserts.
- States:
  - COLLECT: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Symbol accept = in_valid & in_ready, evaluated on the rising edge.
- On accept in COLLECT:
  - S1 <= (S1 · α) ^ in_symbol.
  - S2 <= (S2 · α^2) ^ in_symbol.
  - count <= count + 1.
- GF multiply by a constant is pure XOR/shift logic in polynomial basis; no log/antilog tables in this block.
  - ·α: {s[1], s[0]^s[2], s[2]}.
  - ·α^2: apply ·α twice.
- Accept with count == N-1:
  - Final update is written to the syndrome outputs.
  - count <= 0; state <= HOLD.
  - out_valid rises the cycle after the 7th accept. Latency is 1 clock from last accept to out_valid.
- No accept (in_valid = 0) in COLLECT: all state holds; gaps between symbols are legal.
- HOLD:
  - syndrome1, syndrome2 and error_detected are stable while out_valid = 1 and out_ready = 0.
  - When out_ready = 1: out_valid <= 0, accumulators <= 0, state <= COLLECT.
  - in_ready returns to 1 the following cycle, giving one bubble between codewords.
- in_valid asserted in HOLD is ignored; in_ready = 0, no symbol is consumed.
- out_ready asserted in COLLECT has no effect.
- Reset asserted mid-codeword or in HOLD:
  - Partial codeword is discarded; all registers return to reset values immediately.
  - No out_valid is produced for the aborted word.
- Codeword boundary is fixed at N accepts; there is no last/sideband input. The count wraps 6 -> 0 only via the HOLD transition.
- Throughput: at most one codeword per N+1 cycles.
- Every output is a direct register output, so nothing changes combinationally from inputs.

Test Plan:
- All-zero codeword, 7 back-to-back symbols of 0, out_ready = 1 -> out_valid one cycle after 7th accept; S1 = 0, S2 = 0, error_detected = 0; in_ready = 1 one cycle later.
- Valid codeword g(x) streamed as 0,0,0,0,1,6,3 -> S1 = 0, S2 = 0, error_detected = 0.
- Same codeword with last symbol corrupted (3 -> 2, error value 1 at degree 0) -> S1 = 1, S2 = 1, error_detected = 1.
- Zero codeword with first symbol = 1 (error at degree 6) -> S1 = 3'b101 (α^6), S2 = 3'b111 (α^5), error_detected = 1.
- Backpressure and bubbles:
  - Random in_valid gaps during input of 0,0,0,0,1,6,3 -> still S1 = S2 = 0.
  - Hold out_ready = 0 for 5 cycles -> outputs stable and in_ready = 0 throughout.
  - in_valid = 1 during HOLD -> the symbol is not consumed; the next codeword starts only after out_ready.
- Assert reset_n = 0 after 4 symbols of a word, release, then stream the zero codeword -> no spurious out_valid; result S1 = S2 = 0 after exactly 7 new accepts.
